// File: rtl/add_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_arb_pkg
//  Description : Shared types and constants for the add_arbiter block:
//                FSM state encoding, datapath width and the result record.
//  Revision    : 1.0  initial release
// ============================================================================
package add_arb_pkg;

    // Datapath width of operands and results.
    localparam int DATA_W   = 32;

    // Widest requester tag the block supports (NUM_REQ up to 8).
    localparam int MAX_ID_W = 3;

    // Sequencer states, explicitly two bits wide.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Registered response record returned to the consumer.
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [DATA_W-1:0]   sum;
        logic                ovf;
    } result_t;

endpackage : add_arb_pkg
`default_nettype wire

// File: rtl/cla.sv
`default_nettype none
// ============================================================================
//  Module      : cla
//  Description : Purely combinational carry-lookahead adder built from 4-bit
//                lookahead groups with a group-level carry chain.
//  Revision    : 1.0  initial release
// ============================================================================
module cla #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_NGRP = WIDTH / 4;

    // Carry into each 4-bit group; w_c[c_NGRP] is the final carry-out.
    logic [c_NGRP:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[c_NGRP];

    genvar k;
    // One lookahead group per nibble; each resolves its internal carries
    // directly from generate/propagate and the group carry-in.
    for (k = 0; k < c_NGRP; k++) begin : g_grp
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [3:0] w_cc;

        assign w_g = a[4*k +: 4] & b[4*k +: 4];
        assign w_p = a[4*k +: 4] ^ b[4*k +: 4];

        assign w_cc[0] = w_c[k];
        assign w_cc[1] = w_g[0] | (w_p[0] & w_c[k]);
        assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & w_c[k]);
        assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0])
                       | (&w_p[2:0] & w_c[k]);

        assign w_c[k+1] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1])
                        | (&w_p[3:1] & w_g[0]) | (&w_p[3:0] & w_c[k]);

        assign sum[4*k +: 4] = w_p ^ w_cc;
    end

endmodule : cla
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Selects the first valid
//                requester searching upward from last_grant+1, wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic               grant_vld,
    output logic [ID_W-1:0]    grant_idx
);

    // Pick the valid requester with the smallest rotational distance from
    // last_grant+1; the 2*NUM_REQ bias keeps the modulo operand positive.
    always_comb begin
        int w_best;
        int w_dist;
        grant_vld = 1'b0;
        grant_idx = '0;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + 2 * NUM_REQ - int'(last_grant) - 1) % NUM_REQ;
            if (req_valid[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                grant_vld = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : add_arbiter
//  Description : Round-robin arbiter/sequencer sharing one 32-bit CLA among
//                NUM_REQ requesters; returns an ID-tagged registered result.
//  Revision    : 1.0  initial release
// ============================================================================
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_ovf
);

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic                r_op_cin;
    logic [ID_W-1:0]     r_op_id;
    logic [ID_W-1:0]     r_last_grant;

    result_t             r_rsp;
    logic                r_rsp_valid;
    result_t             w_result;

    logic                w_grant_vld;
    logic [ID_W-1:0]     w_grant_idx;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic                w_accept;

    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic                w_sel_sub;

    logic [DATA_W-1:0]   w_sum;
    logic                w_unused_cout;
    logic                w_unused_id;

    rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .ID_W       (ID_W)
    ) u_rr_pick (
        .req_valid  (req_valid),
        .last_grant (r_last_grant),
        .grant_vld  (w_grant_vld),
        .grant_idx  (w_grant_idx)
    );

    // The shared adder only ever sees registered operands.
    cla #(
        .WIDTH (DATA_W)
    ) u_cla (
        .a     (r_op_a),
        .b     (r_op_b),
        .cin   (r_op_cin),
        .sum   (w_sum),
        .cout  (w_unused_cout)
    );

    // Mux the granted requester's operands onto the capture path.
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_sel_a   = req_a[i*DATA_W +: DATA_W];
                w_sel_b   = req_b[i*DATA_W +: DATA_W];
                w_sel_sub = req_sub[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the one-hot ready, which is only offered in IDLE
    // and never while reset is asserted.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        w_req_ready[i] = rst_n && (w_grant_idx == ID_W'(i));
                    end
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept = (r_state == IDLE) && w_grant_vld;

    // Subtraction is folded in at capture (inverted B, carry-in 1), so the
    // overflow test below sees the operand the adder actually consumed.
    always_comb begin
        w_result     = '0;
        w_result.id  = MAX_ID_W'(r_op_id);
        w_result.sum = w_sum;
        w_result.ovf = (r_op_a[DATA_W-1] == r_op_b[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != r_op_a[DATA_W-1]);
    end

    // Operand capture, grant pointer and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_cin     <= 1'b0;
            r_op_id      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_rsp        <= '0;
            r_rsp_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a       <= w_sel_a;
                r_op_b       <= w_sel_b ^ {DATA_W{w_sel_sub}};
                r_op_cin     <= w_sel_sub;
                r_op_id      <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (r_state == EXEC) begin
                r_rsp       <= w_result;
                r_rsp_valid <= 1'b1;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Carry-out is intentionally discarded; upper tag bits beyond ID_W are
    // always zero.
    assign w_unused_id = ^r_rsp.id;

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp.id[ID_W-1:0];
    assign rsp_sum   = r_rsp.sum;
    assign rsp_ovf   = r_rsp.ovf;

endmodule : add_arbiter
`default_nettype wire

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer that shares one 32-bit carry-lookahead adder (`cla`) among `NUM_REQ` requesters. Each requester presents an add or subtract job over a valid/ready handshake. The block registers the winning operands, drives the shared adder, and returns a registered sum tagged with the requester ID. It sits between the issuing units and the single adder instance, so the adder itself stays purely combinational.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag.
- Reset is synchronous and active-low.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester job valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  NUM_REQ*32  operand A, requester i in bits [32*i +: 32].
- `req_b`  in  NUM_REQ*32  operand B, same packing as `req_a`.
- `req_sub`  in  NUM_REQ  1 means A−B, 0 means A+B.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester that owns the result.
- `rsp_sum`  out  32  A+B or A−B, modulo 2^32.
- `rsp_ovf`  out  1  signed two's-complement overflow of the operation.

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, the grant goes to the first valid requester, searching upward from `last_grant+1` and wrapping modulo NUM_REQ.
  - `req_ready[grant]` is driven high combinationally in the same cycle. Accept happens when valid and ready are both high.
  - On accept, register: `op_a = req_a[g]`, `op_b = req_b[g] ^ {32{req_sub[g]}}`, `op_cin = req_sub[g]`, `op_id = g`. Then set `last_grant = g` and go to EXEC.
  - If no request is valid, stay in IDLE and leave `last_grant` unchanged.
- **EXEC**
  - The shared adder is fed `op_a`, `op_b`, `op_cin`.
  - Register `rsp_sum = sum`, `rsp_id = op_id`, and `rsp_ovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31])`.
  - Set `rsp_valid = 1` and go to RESP.
- **RESP**
  - Hold `rsp_*` stable while `rsp_valid && !rsp_ready`.
  - On `rsp_ready`, clear `rsp_valid` and go to IDLE.
- `req_ready` is all-zero outside IDLE.
- Requesters must hold valid and data stable until accepted. They must not make `req_valid` depend on `req_ready`.
- Subtraction overflow uses the inverted B, so 0x80000000 − 1 flags overflow.
- Operands are exactly 32 bits. Carry-out is discarded, and the sum wraps modulo 2^32.
- Reset (`rst_n == 0` at an edge), including mid-operation:
  - state goes to IDLE and any in-flight job is dropped;
  - `rsp_valid`, `rsp_sum`, `rsp_id`, `rsp_ovf`, and the operand registers go to 0;
  - `last_grant` goes to NUM_REQ−1, so requester 0 has first priority after reset;
  - `req_ready` is 0 while `rst_n` is low.
- A request that arrives while the block is busy waits; there is no queue. Fairness follows from the rotating pointer: a continuously valid requester is served within NUM_REQ grants.

## Timing
- Accept in cycle N → `rsp_valid` high from cycle N+2.
- If `rsp_ready` is high at N+2, IDLE is reached at N+3 and the next accept can happen in N+3. Peak throughput is therefore one job per 3 cycles.
- Backpressure stretches RESP indefinitely. No new job is accepted during backpressure.
- The combinational path in IDLE runs from `req_valid` through the grant logic to `req_ready`. The adder path is register to register (operand regs → `cla` → result regs).

## Structure
- Shared package `add_arb_pkg` holds:
  - the `state_t` enum {IDLE, EXEC, RESP};
  - `localparam DATA_W = 32`;
  - the result struct `{id, sum, ovf}`.
- One natural sub-module, `rr_pick`: a combinational round-robin picker with inputs `req_valid` and `last_grant`, and outputs `grant_vld` and `grant_idx`.
- The existing `cla` adder is instantiated once, unmodified.

## Test plan
1. After reset, only requester 2 is valid with A=5, B=7, add → `req_ready=4'b0100` in the same cycle; 2 cycles later `rsp_valid=1`, `rsp_id=2`, `rsp_sum=12`, `rsp_ovf=0`.
2. Requester 1 sends A=3, B=5, sub → `rsp_sum=0xFFFFFFFE`, `rsp_ovf=0`. Requester 0 sends A=0x7FFFFFFF, B=1, add → `rsp_sum=0x80000000`, `rsp_ovf=1`. Requester 0 sends A=0x80000000, B=1, sub → `rsp_ovf=1`.
3. All 4 requesters are held valid with `rsp_ready` tied to 1 → grant order is 0, 1, 2, 3, 0, …, and there are exactly 3 cycles between consecutive accepts.
4. `rsp_ready` is held 0 for 10 cycles after a result → `rsp_*` stay stable, all `req_ready` stay 0, and the next accept happens 1 cycle after `rsp_ready` rises.
5. `rst_n` is pulsed low for 1 cycle while in EXEC → no `rsp_valid` appears, all outputs read 0, and the next grant goes to requester 0 when both 0 and 3 are valid.
6. A+B with A=0xFFFFFFFF, B=1 → `rsp_sum=0`, `rsp_ovf=0`, confirming the carry-out is discarded.
